// File: rtl/conv_frame_loader.sv
// conv_frame_loader: packs a row-major valid/ready byte stream into the flat
// matrix consumed by the 9x9 convolution core, pulses the core's start and
// holds the matrix frozen until the core reports done.
//
// Optional framing check: define CONV_FRAME_LOADER_FRAME_CHECK_EN to sample
// in_last_i on every transfer and raise the sticky err_o on early or missing
// last markers. Without it in_last_i is ignored and err_o stays 0.
module conv_frame_loader #(
  parameter int unsigned ROWS   = 9,
  parameter int unsigned COLS   = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_W-1:0]             in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_last_i,
  output logic [ROWS*COLS*DATA_W-1:0]   conv_matrix_o,
  output logic                          conv_start_o,
  input  logic                          conv_done_i,
  output logic                          busy_o,
  output logic [15:0]                   frame_count_o,
  output logic                          err_o
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned MAT_W = N * DATA_W;
  localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StLoad, StStart, StWait} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                in_ready_q;
  logic                conv_start_q;
  logic                busy_q;
  logic                err_q;
  logic [15:0]         frame_count_q;
  logic [MAT_W-1:0]    mat_q;

  logic                xfer;
  logic                cnt_last;
  logic                early_last;
  logic                missing_last;

  // Transfer qualification and position of the current element in the frame.
  always_comb begin
    xfer     = in_valid_i & in_ready_q;
    cnt_last = (cnt_q == CntW'(N - 1));
  end

`ifdef CONV_FRAME_LOADER_FRAME_CHECK_EN
  // Framing violations, only meaningful when a transfer happens.
  always_comb begin
    early_last   = in_last_i & ~cnt_last;
    missing_last = ~in_last_i & cnt_last;
  end
`else
  logic unused_in_last;

  // Framing check disabled: in_last is ignored entirely.
  always_comb begin
    early_last     = 1'b0;
    missing_last   = 1'b0;
    unused_in_last = in_last_i;
  end
`endif

  // Frame FSM with all outputs registered; matrix only written on LOAD transfers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StLoad;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      conv_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
      mat_q         <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          // Ready comes up on the first LOAD cycle after reset or WAIT.
          in_ready_q <= 1'b1;
          if (xfer) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (cnt_q == CntW'(i)) begin
                mat_q[i*DATA_W +: DATA_W] <= in_data_i;
              end
            end
            if (early_last) begin
              // Drop the partial frame; written elements linger until overwritten.
              err_q <= 1'b1;
              cnt_q <= '0;
            end else if (cnt_last) begin
              if (missing_last) begin
                err_q <= 1'b1;
              end
              cnt_q        <= '0;
              state_q      <= StStart;
              conv_start_q <= 1'b1;
              in_ready_q   <= 1'b0;
              busy_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

        StStart: begin
          conv_start_q  <= 1'b0;
          state_q       <= StWait;
          frame_count_q <= frame_count_q + 16'd1;
        end

        StWait: begin
          if (conv_done_i) begin
            state_q    <= StLoad;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state_q    <= StLoad;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs.
  always_comb begin
    in_ready_o    = in_ready_q;
    conv_matrix_o = mat_q;
    conv_start_o  = conv_start_q;
    busy_o        = busy_q;
    frame_count_o = frame_count_q;
    err_o         = err_q;
  end

endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Upstream feeder for the 9x9 convolution core.
- Accepts a row-major byte stream over a valid/ready handshake and packs it into the flat 648-bit matrix the core consumes.
- Pulses the core's start, holds the matrix stable while the core runs, and waits for done before accepting the next frame.
- Sits between the pixel source (UART/DMA front end) and the convolution core.

Parameters:
- ROWS, 9, matrix rows.
- COLS, 9, matrix columns.
- DATA_W, 8, bits per element.
- Derived, not overridable: N = ROWS*COLS (81); MAT_W = N*DATA_W (648).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- in_data  in  DATA_W  stream element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept an element.
- in_last  in  1  marks the final element of a frame; used only with FRAME_CHECK_EN.
- conv_matrix  out  MAT_W  packed matrix to the core's input_matrix.
- conv_start  out  1  one-cycle start pulse to the core.
- conv_done  in  1  core's done.
- busy  out  1  frame handed off, waiting for conv_done.
- frame_count  out  16  frames handed to the core, mod 2^16.
- err  out  1  sticky framing error.

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to LOAD and the element counter cnt goes to 0.
  - in_ready=0, conv_start=0, conv_matrix=0, busy=0, frame_count=0, err=0.
  - A partial frame is discarded. A reset during WAIT abandons the in-flight frame and does not count it.
- States: LOAD, START, WAIT. All outputs are registered.
- LOAD:
  - in_ready=1, from the first cycle after reset release.
  - A transfer occurs on an edge where in_valid && in_ready.
  - On a transfer: conv_matrix[cnt*DATA_W +: DATA_W] <= in_data, then cnt++. Element (i,j) therefore lands at bit offset (i*COLS+j)*DATA_W.
  - When the transfer is at cnt==N-1: cnt<=0, state<=START, conv_start<=1, in_ready<=0, busy<=1.
  - in_valid=0 stalls with no state change; gaps are allowed anywhere in a frame.
- START (exactly 1 cycle):
  - conv_start is high during this cycle only.
  - At the next edge: conv_start<=0, state<=WAIT, frame_count++ (wraps 65535 to 0).
- WAIT:
  - in_ready=0 and conv_matrix is frozen.
  - conv_done is sampled only in WAIT; when high: state<=LOAD, in_ready<=1, busy<=0.
  - conv_done asserted in LOAD or START is ignored.
- Latency:
  - conv_start is high in the cycle immediately after the edge that accepts element N-1.
  - in_ready rises in the cycle after the edge that samples conv_done=1.
- conv_matrix changes only on LOAD transfers. It is stable from the START cycle until the first transfer of the next frame.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro: CONV_FRAME_LOADER_FRAME_CHECK_EN.
- Defined:
  - in_last is sampled on each transfer.
  - in_last=1 at cnt<N-1 (early last): set err, cnt<=0, partial frame dropped, no conv_start, remain in LOAD. Elements already written stay in conv_matrix until overwritten.
  - in_last=0 at cnt==N-1 (missing last): set err; the frame is still issued normally.
  - err clears only on reset.
- Undefined: in_last is ignored and err is held at 0.

Test Plan:
- Reset, then stream 81 elements with value = index, in_valid held high: in_ready high for exactly 81 cycles. One-cycle conv_start follows the last transfer. conv_matrix[(i*9+j)*8 +: 8] == i*9+j. frame_count == 1, busy == 1.
- Hold WAIT for 50 cycles, then drive conv_done high for 1 cycle, with in_valid high and alternate data 0xFF presented throughout WAIT: conv_matrix is unchanged throughout, busy drops and in_ready rises the cycle after conv_done, and no stray element is captured.
- Insert a random in_valid gap of 0–5 cycles before each element: conv_matrix is identical to the first scenario and exactly one conv_start occurs per frame.
- Deassert rst at element 40 of a frame, then send a full frame of 0xA5: conv_matrix is all 0xA5, frame_count == 1, no conv_start before element 81.
- With FRAME_CHECK_EN, assert in_last at element 10, then send a correct 81-element frame: err == 1, no conv_start after element 10, exactly one conv_start after the correct frame, frame_count == 1.
- Run 3 back-to-back frames with conv_done returned 2 cycles after each start: frame_count == 3, and each conv_matrix matches its source frame.
